// File: rtl/data_fetch_load_if.sv
// data_fetch_load_if: control-unit command, data-memory read and PE write buses of the tile loader
interface data_fetch_load_if #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 8
);
  logic              ADDR_START;
  logic              ADDR_RST;
  logic [3:0]        ADDRESS;
  logic [1:0]        DIMEN;
  logic [1:0]        PE_SEL;
  logic              PE_SEL_2x2;
  logic              PE_SEL_4;
  logic              MEM_RD_EN;
  logic [MEM_AW-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_RDATA;
  logic [3:0]        PE_WR_EN;
  logic [1:0]        PE_WR_ROW;
  logic [1:0]        PE_WR_COL;
  logic [DATA_W-1:0] PE_WR_DATA;
  logic              FETCH_DONE;
  modport slave (
    input  ADDR_START, ADDR_RST, ADDRESS, DIMEN, PE_SEL, PE_SEL_2x2, PE_SEL_4, MEM_RDATA,
    output MEM_RD_EN, MEM_ADDR, PE_WR_EN, PE_WR_ROW, PE_WR_COL, PE_WR_DATA, FETCH_DONE
  );
  modport master (
    output ADDR_START, ADDR_RST, ADDRESS, DIMEN, PE_SEL, PE_SEL_2x2, PE_SEL_4, MEM_RDATA,
    input  MEM_RD_EN, MEM_ADDR, PE_WR_EN, PE_WR_ROW, PE_WR_COL, PE_WR_DATA, FETCH_DONE
  );
endinterface

// File: rtl/data_fetch_load.sv
// data_fetch_load: reads an NxN tile row-major from data memory and writes it into the selected PE buffers
module data_fetch_load #(
  parameter int DATA_W    = 16,
  parameter int MEM_AW    = 8,
  parameter int BLK_SHIFT = 4
) (
  input logic CLK,
  input logic RSTN,
  data_fetch_load_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t            state, state_n;
  logic [1:0]        row, col, dim, row_n, col_n, dim_n, wr_row, wr_col;
  logic [3:0]        mask, mask_n, wr_en, wr_en_n;
  logic [MEM_AW-1:0] base, base_n;
  logic              abort, last;
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      dim    <= '0;
      mask   <= '0;
      base   <= '0;
      wr_en  <= '0;
      wr_row <= '0;
      wr_col <= '0;
    end else begin
      state  <= state_n;
      row    <= row_n;
      col    <= col_n;
      dim    <= dim_n;
      mask   <= mask_n;
      base   <= base_n;
      wr_en  <= wr_en_n;
      wr_row <= row;
      wr_col <= col;
    end
  end
  // Dropping ADDR_START mid-read is treated exactly like ADDR_RST, including cancelling the in-flight write.
  always_comb begin
    abort   = bus.ADDR_RST | (state == READ & ~bus.ADDR_START);
    last    = row == dim & col == dim;
    state_n = state;
    row_n   = row;
    col_n   = col;
    dim_n   = dim;
    mask_n  = mask;
    base_n  = base;
    wr_en_n = (state == READ & ~abort) ? mask : '0;
    case (state)
      IDLE: if (bus.ADDR_START) begin
        state_n = READ;
        row_n   = '0;
        col_n   = '0;
        dim_n   = bus.DIMEN;
        base_n  = MEM_AW'(bus.ADDRESS) << BLK_SHIFT;
        mask_n  = bus.PE_SEL_4 ? 4'b1111 : bus.PE_SEL_2x2 ? (bus.PE_SEL[1] ? 4'b1100 : 4'b0011) : 4'b0001 << bus.PE_SEL;
      end
      READ: begin
        state_n = last ? DRAIN : READ;
        col_n   = col == dim ? '0 : col + 2'd1;
        row_n   = last ? '0 : col == dim ? row + 2'd1 : row;
      end
      DRAIN: state_n = DONE;
      DONE: state_n = bus.ADDR_START ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      row_n   = '0;
      col_n   = '0;
    end
  end
  assign bus.MEM_RD_EN  = state == READ;
  assign bus.MEM_ADDR   = bus.MEM_RD_EN ? base + MEM_AW'({row, col}) : '0;
  assign bus.PE_WR_EN   = wr_en;
  assign bus.PE_WR_ROW  = wr_row;
  assign bus.PE_WR_COL  = wr_col;
  assign bus.PE_WR_DATA = bus.MEM_RDATA;
  assign bus.FETCH_DONE = state == DONE;
endmodule

// File: tb/tb_data_fetch_load.sv
// tb_data_fetch_load: directed tile loads against a memory model, with read/write scoreboards
module tb_data_fetch_load;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  data_fetch_load_if #(.DATA_W(16), .MEM_AW(8)) bus ();
  data_fetch_load #(.DATA_W(16), .MEM_AW(8), .BLK_SHIFT(4)) dut (.CLK(clk), .RSTN(rstn), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  rq[$];
  logic [23:0] wq[$];
  bit mon_en = 0;
  bit fd_seen = 0;
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction
  always @(posedge clk) if (bus.MEM_RD_EN) bus.MEM_RDATA <= mem_word(bus.MEM_ADDR);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    if (bus.FETCH_DONE) fd_seen = 1;
    if (bus.MEM_RD_EN) begin
      check("read_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) check("mem_addr", 32'(bus.MEM_ADDR), 32'(rq.pop_front()));
    end else check("mem_addr_idle", 32'(bus.MEM_ADDR), 0);
    if (bus.PE_WR_EN != 4'b0) begin
      check("write_expected", 32'(wq.size() != 0), 1);
      if (wq.size() != 0)
        check("pe_write", 32'({bus.PE_WR_EN, bus.PE_WR_ROW, bus.PE_WR_COL, bus.PE_WR_DATA}), 32'(wq.pop_front()));
    end
  end
  task automatic expect_load(input logic [3:0] addr, input logic [1:0] dim, input logic [3:0] mask, input int nrd, input int nwr);
    int n = int'(dim) + 1;
    for (int i = 0; i < n * n; i++) begin
      logic [7:0] a;
      a = {addr, 4'h0} + 8'(4 * (i / n) + i % n);
      if (i < nrd) rq.push_back(a);
      if (i < nwr) wq.push_back({mask, 2'(i / n), 2'(i % n), mem_word(a)});
    end
  endtask
  task automatic drive(input logic [3:0] addr, input logic [1:0] dim, input logic [1:0] sel, input logic s2, input logic s4);
    bus.ADDRESS    = addr;
    bus.DIMEN      = dim;
    bus.PE_SEL     = sel;
    bus.PE_SEL_2x2 = s2;
    bus.PE_SEL_4   = s4;
    bus.ADDR_START = 1'b1;
  endtask
  task automatic drained(input string tag);
    #1;
    check({tag, "_reads_left"}, 32'(rq.size()), 0);
    check({tag, "_writes_left"}, 32'(wq.size()), 0);
    rq.delete();
    wq.delete();
  endtask
  task automatic run_load(input string tag, input logic [3:0] addr, input logic [1:0] dim, input logic [1:0] sel,
                          input logic s2, input logic s4, input logic [3:0] mask, input int hold, input bit use_rst, input bit scramble);
    int n = int'(dim) + 1;
    int cyc = 0;
    expect_load(addr, dim, mask, n * n, n * n);
    drive(addr, dim, sel, s2, s4);
    @(posedge clk);
    do begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 2) begin
        bus.ADDRESS = ~addr;
        bus.DIMEN = ~dim;
        bus.PE_SEL = ~sel;
        bus.PE_SEL_4 = 1'b1;
      end
    end while (!bus.FETCH_DONE && cyc < 40);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(n * n + 2));
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_done_held"}, 32'(bus.FETCH_DONE), 1);
      check({tag, "_rd_en_in_done"}, 32'(bus.MEM_RD_EN), 0);
    end
    if (use_rst) bus.ADDR_RST = 1'b1;
    else bus.ADDR_START = 1'b0;
    @(negedge clk);
    check({tag, "_done_cleared"}, 32'(bus.FETCH_DONE), 0);
    check({tag, "_wr_en_idle"}, 32'(bus.PE_WR_EN), 0);
    bus.ADDR_RST = 1'b0;
    bus.ADDR_START = 1'b0;
    drained(tag);
  endtask
  task automatic run_abort(input string tag, input int kind, input int k);
    expect_load(4'h4, 2'd3, 4'b0001, k, k - 1);
    drive(4'h4, 2'd3, 2'd0, 1'b0, 1'b0);
    fd_seen = 0;
    @(posedge clk);
    repeat (k) @(negedge clk);
    if (kind == 0) bus.ADDR_RST = 1'b1;
    else if (kind == 1) bus.ADDR_START = 1'b0;
    else begin
      rstn = 1'b0;
      bus.ADDR_START = 1'b0;
    end
    @(negedge clk);
    check({tag, "_rd_en"}, 32'(bus.MEM_RD_EN), 0);
    check({tag, "_wr_en"}, 32'(bus.PE_WR_EN), 0);
    if (kind == 2) check({tag, "_row_col"}, 32'({bus.PE_WR_ROW, bus.PE_WR_COL}), 0);
    bus.ADDR_RST = 1'b0;
    bus.ADDR_START = 1'b0;
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check({tag, "_no_fetch_done"}, 32'(fd_seen), 0);
    drained(tag);
  endtask
  initial begin
    bus.ADDR_START = 1'b0;
    bus.ADDR_RST = 1'b0;
    bus.ADDRESS = '0;
    bus.DIMEN = '0;
    bus.PE_SEL = '0;
    bus.PE_SEL_2x2 = 1'b0;
    bus.PE_SEL_4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_en", 32'(bus.MEM_RD_EN), 0);
    check("rst_addr", 32'(bus.MEM_ADDR), 0);
    check("rst_wr_en", 32'(bus.PE_WR_EN), 0);
    check("rst_row_col", 32'({bus.PE_WR_ROW, bus.PE_WR_COL}), 0);
    check("rst_done", 32'(bus.FETCH_DONE), 0);
    rstn = 1'b1;
    mon_en = 1;
    @(negedge clk);
    run_load("t1_4x4", 4'h2, 2'd3, 2'd1, 1'b0, 1'b0, 4'b0010, 0, 0, 0);
    run_load("t2_2x2_pair", 4'h5, 2'd1, 2'd2, 1'b1, 1'b0, 4'b1100, 0, 0, 0);
    run_load("t3_1x1_bcast", 4'hF, 2'd0, 2'd0, 1'b1, 1'b1, 4'b1111, 0, 0, 0);
    run_load("t3x3_scramble", 4'h7, 2'd2, 2'd3, 1'b0, 1'b0, 4'b1000, 0, 0, 1);
    run_load("t5_handshake", 4'h9, 2'd1, 2'd0, 1'b1, 1'b0, 4'b0011, 3, 1, 0);
    run_abort("t4_addr_rst", 0, 5);
    run_abort("t7_start_drop", 1, 2);
    run_abort("t6_rstn", 2, 4);
    run_load("t6_reload", 4'h3, 2'd3, 2'd2, 1'b0, 1'b0, 4'b0100, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
